// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - M-stage data-memory access controller on a req/ack bus
module dmem_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m_MemRead,
  input  logic              m_MemWrite,
  input  logic [2:0]        m_size,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [31:0]       m_wdata,
  output logic              stall_mem,
  output logic [31:0]       read_data,
  output logic              misalign,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] cnt;
  logic [2:0]  size_q;
  logic [1:0]  off_q;

  logic        access;
  logic        legal;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] lane;
  logic [31:0] load_fmt;

  // Decode legality, byte enables and lane-replicated store data of the M-stage request
  always_comb begin
    access     = m_MemRead | m_MemWrite;
    legal      = 1'b0;
    be_next    = 4'b1111;
    wdata_next = m_wdata;
    case (m_size)
      3'b000:         legal = 1'b1;
      3'b001:         legal = ~m_addr[0];
      3'b010:         legal = (m_addr[1:0] == 2'b00);
      3'b100, 3'b101: legal = ~m_MemWrite;
      default:        legal = 1'b0;
    endcase
    case (m_size[1:0])
      2'b00: begin
        be_next    = 4'b0001 << m_addr[1:0];
        wdata_next = {4{m_wdata[7:0]}};
      end
      2'b01: begin
        be_next    = m_addr[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{m_wdata[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = m_wdata;
      end
    endcase
  end

  // Shift the addressed lane down and sign/zero-extend it for the registered load size
  always_comb begin
    lane = mem_rdata >> {off_q, 3'b000};
    case (size_q)
      3'b000:  load_fmt = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_fmt = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_fmt = {24'd0, lane[7:0]};
      3'b101:  load_fmt = {16'd0, lane[15:0]};
      default: load_fmt = mem_rdata;
    endcase
  end

  // Stall and misalign are combinational so the pipeline reacts in the request cycle; reset forces both low
  always_comb begin
    stall_mem = rst_n & (((state == IDLE) & access & legal) | (state == BUS));
    misalign  = rst_n & (state == IDLE) & access & ~legal;
  end

  // Access FSM: capture the request, run the bus with a timeout, present the result for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      size_q    <= '0;
      off_q     <= '0;
      read_data <= '0;
      bus_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            if (legal) begin
              mem_req   <= 1'b1;
              mem_we    <= m_MemWrite;
              mem_addr  <= {m_addr[ADDR_W-1:2], 2'b00};
              mem_be    <= be_next;
              mem_wdata <= wdata_next;
              size_q    <= m_size;
              off_q     <= m_addr[1:0];
              cnt       <= '0;
              state     <= BUS;
            end else begin
              read_data <= '0;
            end
          end
        end
        BUS: begin
          if (mem_ack) begin
            read_data <= load_fmt;
            mem_req   <= 1'b0;
            state     <= DONE;
          end else if (cnt == CNT_LAST) begin
            read_data <= '0;
            bus_err   <= 1'b1;
            mem_req   <= 1'b0;
            state     <= DONE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - randomized self-checking bench for dmem_ctrl against a behavioural model
module tb_dmem_ctrl;

  localparam int TO = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_MemRead, m_MemWrite;
  logic [2:0]  m_size;
  logic [31:0] m_addr, m_wdata;
  logic        stall_mem, misalign, bus_err, mem_req, mem_we, mem_ack;
  logic [31:0] read_data, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int tests = 0;
  int fails = 0;

  // expectations for the current cycle, consumed by the compare process
  logic        chk_en = 1'b0;
  logic        e_stall, e_req, e_mis, e_err, e_we, e_rd_chk;
  logic [31:0] e_addr, e_wdata, e_rd;
  logic [3:0]  e_be;

  // model state: last value read_data must hold
  logic [31:0] model_rd;
  logic        rd_known;

  dmem_ctrl #(.TIMEOUT(TO), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_MemRead(m_MemRead), .m_MemWrite(m_MemWrite), .m_size(m_size),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .stall_mem(stall_mem), .read_data(read_data), .misalign(misalign), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_legal(input logic [2:0] sz, input logic [31:0] a, input bit wr);
    if (sz == 3'b000) return 1;
    if (sz == 3'b001) return (a % 2) == 0;
    if (sz == 3'b010) return (a % 4) == 0;
    if (sz == 3'b100 || sz == 3'b101) return !wr;
    return 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] sz, input logic [31:0] a);
    int off = int'(a % 4);
    if (sz == 3'b000 || sz == 3'b100) return 4'(1 << off);
    if (sz == 3'b001 || sz == 3'b101) return (off >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] sz, input logic [31:0] d);
    logic [31:0] b = d & 32'hFF;
    logic [31:0] h = d & 32'hFFFF;
    if (sz == 3'b000) return b * 32'h01010101;
    if (sz == 3'b001) return h * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_fmt(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    int off = int'(a % 4);
    if (sz == 3'b000 || sz == 3'b100) begin
      v = (rd >> (8 * off)) & 32'hFF;
      if (sz == 3'b000 && v >= 128) v = v | 32'hFFFFFF00;
      return v;
    end
    if (sz == 3'b001 || sz == 3'b101) begin
      v = (rd >> (8 * off)) & 32'hFFFF;
      if (sz == 3'b001 && v >= 32768) v = v | 32'hFFFF0000;
      return v;
    end
    return rd;
  endfunction

  // compare process: every cycle while enabled, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall_mem", 32'(stall_mem), 32'(e_stall));
      chk("mem_req", 32'(mem_req), 32'(e_req));
      chk("misalign", 32'(misalign), 32'(e_mis));
      chk("bus_err", 32'(bus_err), 32'(e_err));
      if (e_req) begin
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_be", 32'(mem_be), 32'(e_be));
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("mem_we", 32'(mem_we), 32'(e_we));
      end
      if (e_rd_chk) chk("read_data", read_data, e_rd);
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input bit stale_ack);
    m_MemRead = 0; m_MemWrite = 0;
    mem_ack = stale_ack; mem_rdata = $urandom;
    e_stall = 0; e_req = 0; e_mis = 0; e_err = 0;
    e_rd_chk = rd_known; e_rd = model_rd;
    cyc;
    mem_ack = 0;
  endtask

  // one full access; waits = BUS cycles without ack before ack, waits >= TO means no ack at all
  task automatic do_access(input bit rd, input bit wr, input logic [2:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rdata, input int waits,
                           input int bus_limit);
    bit lgl = m_legal(sz, a, wr);
    bit timed_out = (waits >= TO);
    m_MemRead = rd; m_MemWrite = wr; m_size = sz; m_addr = a; m_wdata = wd;
    mem_ack = 0; mem_rdata = $urandom;
    e_stall = lgl; e_req = 0; e_mis = !lgl; e_err = 0;
    e_rd_chk = rd_known; e_rd = model_rd;
    cyc;
    if (!lgl) begin
      model_rd = 0; rd_known = 1;
      m_MemRead = 0; m_MemWrite = 0;
      return;
    end
    e_addr = a & ~32'h3; e_be = m_be(sz, a); e_wdata = m_wd(sz, wd); e_we = wr;
    for (int k = 0; k < TO && k < bus_limit; k++) begin
      mem_ack = (k == waits); mem_rdata = rdata;
      e_stall = 1; e_req = 1; e_mis = 0; e_err = 0;
      cyc;
      if (k == waits) break;
    end
    if (bus_limit < TO) return;
    mem_ack = 0; mem_rdata = $urandom;
    if (wr) rd_known = 0;
    else begin
      model_rd = timed_out ? 32'h0 : m_fmt(sz, a, rdata);
      rd_known = 1;
    end
    e_stall = 0; e_req = 0; e_mis = 0; e_err = timed_out;
    e_rd_chk = rd_known; e_rd = model_rd;
    cyc;
    m_MemRead = 0; m_MemWrite = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] sizes [8];
    sizes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

    rst_n = 0; m_MemRead = 0; m_MemWrite = 0; m_size = 0; m_addr = 0; m_wdata = 0;
    mem_ack = 0; mem_rdata = 0;
    model_rd = 0; rd_known = 1;

    // model pinned to hand-computed values
    chk("pin_lb", m_fmt(3'b000, 32'h203, 32'h80112233), 32'hFFFFFF80);
    chk("pin_lbu", m_fmt(3'b100, 32'h203, 32'h80112233), 32'h00000080);
    chk("pin_sh_wd", m_wd(3'b001, 32'h0000ABCD), 32'hABCDABCD);
    chk("pin_sh_be", 32'(m_be(3'b001, 32'h302)), 32'hC);
    chk("pin_lh_hi", m_fmt(3'b001, 32'h002, 32'h8001_7FFF), 32'hFFFF8001);

    #12;
    chk("rst_stall", 32'(stall_mem), 0);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_read_data", read_data, 0);
    chk("rst_bus_err", 32'(bus_err), 0);
    chk("rst_misalign", 32'(misalign), 0);
    chk("rst_be", 32'(mem_be), 0);
    @(posedge clk); #1;
    rst_n = 1;
    chk_en = 1;
    idle_cycle(0);

    // directed accesses
    do_access(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 99);
    chk("lw_result", read_data, 32'hDEADBEEF);
    do_access(1, 0, 3'b000, 32'h203, 0, 32'h80112233, 0, 99);
    chk("lb_result", read_data, 32'hFFFFFF80);
    do_access(1, 0, 3'b100, 32'h203, 0, 32'h80112233, 1, 99);
    chk("lbu_result", read_data, 32'h00000080);
    do_access(0, 1, 3'b001, 32'h302, 32'h0000ABCD, 32'h0, 5, 99);
    do_access(1, 0, 3'b010, 32'h101, 0, 0, 0, 99);
    do_access(1, 0, 3'b001, 32'h001, 0, 0, 0, 99);
    do_access(1, 0, 3'b011, 32'h000, 0, 0, 0, 99);
    do_access(0, 1, 3'b100, 32'h010, 32'h55, 0, 0, 99);
    do_access(1, 0, 3'b010, 32'h500, 0, 32'h12345678, TO, 99);
    chk("timeout_result", read_data, 32'h0);
    do_access(1, 0, 3'b010, 32'h504, 0, 32'hCAFEF00D, TO - 1, 99);
    chk("late_ack_result", read_data, 32'hCAFEF00D);
    do_access(1, 1, 3'b010, 32'h600, 32'h13579BDF, 32'h0, 2, 99);

    // randomized accesses, interleaved with idle cycles carrying stale acks
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 4) == 0) idle_cycle($urandom_range(0, 1) == 1);
      else begin
        bit rd = $urandom_range(0, 1) == 1;
        bit wr = !rd || ($urandom_range(0, 3) == 0);
        do_access(rd, wr, sizes[$urandom_range(0, 7)], $urandom, $urandom, $urandom,
                  $urandom_range(0, TO + 1), 99);
      end
    end

    // reset in the middle of a bus transaction
    do_access(1, 0, 3'b010, 32'h400, 0, 32'h0, TO, 2);
    chk_en = 0;
    #2;
    rst_n = 0;
    #1;
    chk("rst_mid_req", 32'(mem_req), 0);
    chk("rst_mid_stall", 32'(stall_mem), 0);
    chk("rst_mid_rd", read_data, 0);
    m_MemRead = 0; m_MemWrite = 0;
    model_rd = 0; rd_known = 1;
    @(posedge clk); #1;
    rst_n = 1;
    chk_en = 1;
    idle_cycle(1);
    idle_cycle(1);
    do_access(1, 0, 3'b101, 32'h702, 0, 32'h9ABC1234, 1, 99);
    chk("post_rst_lhu", read_data, 32'h00009ABC);
    idle_cycle(0);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Data-memory access controller for the CPU memory stage. It converts M-stage load/store requests into transactions on a variable-latency req/ack data bus, and generates byte enables, store lane replication, and load sign/zero extension. It drives stall_mem so the whole pipeline holds until each access completes. It also detects misaligned accesses and bus timeouts.

Parameters:
TIMEOUT, 255, maximum cycles in BUS state without mem_ack before the access is aborted (1..65535)
ADDR_W, 32, byte address width

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
m_MemRead  input  1  load request in M stage
m_MemWrite  input  1  store request in M stage
m_size  input  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
m_addr  input  ADDR_W  byte address (ALU result)
m_wdata  input  32  store data, right-aligned
stall_mem  output  1  hold all pipeline stages
read_data  output  32  formatted load result, valid in DONE
misalign  output  1  one-cycle pulse: misaligned or illegal-size access
bus_err  output  1  one-cycle pulse: access timed out
mem_req  output  1  bus request
mem_we  output  1  1 = write
mem_addr  output  ADDR_W  word-aligned address, low 2 bits 0
mem_be  output  4  byte enables
mem_wdata  output  32  lane-replicated store data
mem_ack  input  1  bus completion; rdata valid with ack
mem_rdata  input  32  read word

Behaviour:
- The rst_n port is an asynchronous active-low reset on the single clock clk. Reset values: state IDLE, all outputs 0, timeout counter 0. Reset asserted mid-access drops mem_req immediately and abandons the transaction.
- access = m_MemRead | m_MemWrite. If both are set, the access is a write.
- Legality:
  - Halfword with addr[0]=1 is misaligned.
  - Word with addr[1:0]!=0 is misaligned.
  - Sizes 011/110/111 are illegal, and BU/HU on a store is illegal.
- FSM has three states: IDLE, BUS, DONE.
- IDLE, legal access:
  - stall_mem=1 (combinational).
  - Register addr/be/wdata/we/size/byte offset.
  - Next state BUS.
- IDLE, misaligned or illegal access:
  - No bus transaction; stall_mem=0.
  - misalign=1 this cycle; read_data registered 0 at the clock edge.
  - Stay in IDLE.
- BUS:
  - mem_req=1, stall_mem=1; mem_addr/be/wdata/we held stable until ack.
  - Timeout counter increments each BUS cycle.
  - On mem_ack: latch formatted rdata into read_data, next state DONE.
  - Counter reaching TIMEOUT with no ack: read_data=0, bus_err pulses in DONE, next state DONE.
  - An ack arriving in the same cycle as the timeout wins; no error is flagged.
- DONE:
  - stall_mem=0, mem_req=0; the pipeline advances at the end of this cycle.
  - Next state is IDLE unconditionally; the inputs seen in DONE belong to the completed access.
- Minimum latency with a zero-wait bus (ack in the first BUS cycle): 2 stall cycles, result in cycle 3.
- Byte enables:
  - B/BU: be = 1<<addr[1:0].
  - H/HU: be = addr[1] ? 1100 : 0011.
  - W: be = 1111.
- Store data: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
- Load format: select lane by the registered offset; B/H sign-extend, BU/HU zero-extend.
- read_data holds its value until the next completion.
- mem_ack outside BUS is ignored.

Test Plan:
- LW addr 0x100, ack in the first BUS cycle, rdata 0xDEADBEEF -> stall_mem high for 2 cycles, mem_be=1111, mem_addr=0x100, read_data=0xDEADBEEF in DONE, stall low.
- LB addr 0x203 and LBU addr 0x203, rdata 0x80112233 -> mem_be=1000, read_data=0xFFFFFF80 and 0x00000080 respectively.
- SH addr 0x302, wdata 0x0000ABCD, ack after 5 wait cycles -> mem_we=1, mem_addr=0x300, mem_be=1100, mem_wdata=0xABCDABCD held stable for all 6 BUS cycles, stall_mem high for 7 cycles.
- LW addr 0x101 -> misalign pulse, mem_req never asserts, stall_mem=0, read_data=0; also check LH addr 0x001 and size 011.
- TIMEOUT=4, LW with no ack -> mem_req high for exactly 4 cycles, bus_err pulse in DONE, read_data=0, state returns to IDLE. Repeat with ack on cycle 4 -> no bus_err.
- rst_n low during BUS -> mem_req and stall_mem drop asynchronously. After release, a fresh LW completes normally and a stale mem_ack arriving in IDLE is ignored.
